// File: rtl/nios_debug_cmd_sysclk_bridge.sv
// System-clock side of the Nios II debug slave: synchronises the JTAG Update-DR
// toggle, queues {ir, data} commands in a FIFO and decodes accepted commands into pulses.
module nios_debug_cmd_sysclk_bridge #(
  parameter int IR_W        = 2,
  parameter int DATA_W      = 38,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      upd_toggle,
  input  logic [IR_W-1:0]           upd_ir,
  input  logic [DATA_W-1:0]         upd_data,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [IR_W-1:0]           cmd_ir,
  output logic [DATA_W-1:0]         cmd_data,
  output logic [DATA_W-1:0]         jdo,
  output logic [(1<<IR_W)-1:0]      take_action,
  output logic [(1<<IR_W)-1:0]      take_no_action,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      ovf,
  input  logic                      clr_ovf
);

  localparam int AW  = $clog2(DEPTH);
  localparam int NCH = 1 << IR_W;
  localparam int EW  = IR_W + DATA_W;
  localparam int PW  = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0]  PRIME_LAST = PW'(SYNC_STAGES + 1);
  localparam logic [PW-1:0]  PRIME_ONE  = 1;
  localparam logic [AW:0]    PTR_ONE    = 1;
  localparam logic [NCH-1:0] CH_ONE     = 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   tog_prev;
  logic [PW-1:0]          prime_cnt;
  logic                   priming;
  logic                   event_det;

  logic [EW-1:0]          mem [DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic [AW:0]            level;
  logic [AW:0]            level_next;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   ovf_set;
  logic [EW-1:0]          head;
  logic [NCH-1:0]         head_sel;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign priming   = (prime_cnt != PRIME_LAST);
  assign event_det = !priming && (sync_out != tog_prev);

  // tog_prev follows the synchroniser every cycle; during priming events are
  // masked, so the toggle level seen at reset release becomes the baseline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      tog_prev  <= 1'b0;
      prime_cnt <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], upd_toggle};
      tog_prev <= sync_out;
      if (priming) prime_cnt <= prime_cnt + PRIME_ONE;
    end
  end

  // Handshake: the head is transferred on any edge where cmd_valid && cmd_ready;
  // cmd_valid never depends on cmd_ready, and cmd_ready alone does nothing.
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_valid = (level != '0);
  assign pop       = cmd_valid && cmd_ready;
  assign push      = event_det && (!full || pop);
  assign ovf_set   = event_det && full && !pop;

  assign head      = mem[rd_ptr[AW-1:0]];
  assign cmd_ir    = cmd_valid ? head[EW-1:DATA_W] : '0;
  assign cmd_data  = cmd_valid ? head[DATA_W-1:0] : '0;
  assign head_sel  = CH_ONE << head[EW-1:DATA_W];
  assign fifo_level = level;

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + PTR_ONE;
      2'b01:   level_next = level - PTR_ONE;
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {upd_ir, upd_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      level <= level_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      ovf            <= 1'b0;
    end else begin
      take_action    <= (pop &&  head[DATA_W-1]) ? head_sel : '0;
      take_no_action <= (pop && !head[DATA_W-1]) ? head_sel : '0;
      if (pop) jdo <= head[DATA_W-1:0];
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nios_debug_cmd_sysclk_bridge.sv
// Bench for nios_debug_cmd_sysclk_bridge: directed vector table, hand-written
// overflow/reset sequences and randomized traffic against a queue-based model.
module tb_nios_debug_cmd_sysclk_bridge;

  localparam int IR_W   = 2;
  localparam int DATA_W = 38;
  localparam int DEPTH  = 4;
  localparam int S      = 2;
  localparam int NCH    = 1 << IR_W;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int EW     = IR_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              upd_toggle;
  logic [IR_W-1:0]   upd_ir;
  logic [DATA_W-1:0] upd_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [IR_W-1:0]   cmd_ir;
  logic [DATA_W-1:0] cmd_data;
  logic [DATA_W-1:0] jdo;
  logic [NCH-1:0]    take_action;
  logic [NCH-1:0]    take_no_action;
  logic [LW-1:0]     fifo_level;
  logic              ovf;
  logic              clr_ovf;

  nios_debug_cmd_sysclk_bridge #(
    .IR_W(IR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset(reset), .upd_toggle(upd_toggle), .upd_ir(upd_ir),
    .upd_data(upd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .jdo(jdo), .take_action(take_action),
    .take_no_action(take_no_action), .fifo_level(fifo_level), .ovf(ovf),
    .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queued commands, pending toggles (edges until they land)
  logic [EW-1:0]     exp_q[$];
  int                pend[$];
  logic [DATA_W-1:0] m_jdo;
  logic [NCH-1:0]    m_ta;
  logic [NCH-1:0]    m_tna;
  logic              m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend.delete();
    m_jdo = '0;
    m_ta  = '0;
    m_tna = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    logic          ev;
    logic          pop;
    logic          drop;
    int            sz;
    logic [EW-1:0] h;
    if (reset) begin
      model_reset();
      return;
    end
    ev = 1'b0;
    drop = 1'b0;
    foreach (pend[i]) pend[i] = pend[i] - 1;
    if (pend.size() > 0 && pend[0] == 0) begin
      void'(pend.pop_front());
      ev = 1'b1;
    end
    sz = exp_q.size();
    pop = (sz != 0) && cmd_ready;
    m_ta = '0;
    m_tna = '0;
    if (pop) begin
      h = exp_q.pop_front();
      m_jdo = h[DATA_W-1:0];
      if (h[DATA_W-1]) m_ta  = NCH'(1) << h[EW-1:DATA_W];
      else             m_tna = NCH'(1) << h[EW-1:DATA_W];
    end
    if (ev) begin
      if (sz < DEPTH || pop) exp_q.push_back({upd_ir, upd_data});
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
  endtask

  task automatic check_model();
    logic [EW-1:0] h;
    h = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("cmd_valid", 64'(cmd_valid), 64'(exp_q.size() != 0));
    chk("cmd_ir", 64'(cmd_ir), 64'(h[EW-1:DATA_W]));
    chk("cmd_data", 64'(cmd_data), 64'(h[DATA_W-1:0]));
    chk("jdo", 64'(jdo), 64'(m_jdo));
    chk("take_action", 64'(take_action), 64'(m_ta));
    chk("take_no_action", 64'(take_no_action), 64'(m_tna));
    chk("fifo_level", 64'(fifo_level), 64'(exp_q.size()));
    chk("ovf", 64'(ovf), 64'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic drive(input logic tog, input logic [IR_W-1:0] ir,
                       input logic [DATA_W-1:0] d, input logic rdy, input logic clr);
    if (tog !== upd_toggle) pend.push_back(S + 1);
    upd_toggle = tog;
    upd_ir     = ir;
    upd_data   = d;
    cmd_ready  = rdy;
    clr_ovf    = clr;
  endtask

  // One update, with ready/clr applied only on the edge where it lands.
  task automatic upd_wait(input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] d,
                          input logic rdy_ev, input logic clr_ev);
    drive(~upd_toggle, ir, d, 1'b0, 1'b0);
    repeat (S) step();
    cmd_ready = rdy_ev;
    clr_ovf   = clr_ev;
    step();
    cmd_ready = 1'b0;
    clr_ovf   = 1'b0;
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_ir"}, 64'(cmd_ir), 64'd0);
    chk({tag, "_data"}, 64'(cmd_data), 64'd0);
    chk({tag, "_jdo"}, 64'(jdo), 64'd0);
    chk({tag, "_ta"}, 64'(take_action), 64'd0);
    chk({tag, "_tna"}, 64'(take_no_action), 64'd0);
    chk({tag, "_level"}, 64'(fifo_level), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  typedef struct {
    logic              tog;
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              clr;
    logic              exp_valid;
    logic [LW-1:0]     exp_level;
    logic [NCH-1:0]    exp_ta;
    logic [NCH-1:0]    exp_tna;
    logic [DATA_W-1:0] exp_jdo;
    logic              exp_ovf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [DATA_W-1:0] da;
    logic [DATA_W-1:0] db;
    int since;
    int phase;
    da = 38'h20_0000_0001;
    db = 38'h00_0000_0005;
    //          tog  ir    data ready clr  valid lvl  ta       tna      jdo  ovf
    vecs[0] = '{1'b0, 2'd2, da, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b0000, '0, 1'b0};
    vecs[1] = '{1'b0, 2'd2, da, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b0000, '0, 1'b0};
    vecs[2] = '{1'b0, 2'd2, da, 1'b0, 1'b0, 1'b1, 3'd1, 4'b0000, 4'b0000, '0, 1'b0};
    vecs[3] = '{1'b0, 2'd2, da, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0100, 4'b0000, da, 1'b0};
    vecs[4] = '{1'b0, 2'd2, da, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b0000, da, 1'b0};
    vecs[5] = '{1'b1, 2'd1, db, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b0000, da, 1'b0};
    vecs[6] = '{1'b1, 2'd1, db, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b0000, da, 1'b0};
    vecs[7] = '{1'b1, 2'd1, db, 1'b1, 1'b0, 1'b1, 3'd1, 4'b0000, 4'b0000, da, 1'b0};
    vecs[8] = '{1'b1, 2'd1, db, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b0010, db, 1'b0};
    vecs[9] = '{1'b1, 2'd1, db, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b0000, db, 1'b0};

    model_reset();
    reset      = 1'b1;
    upd_toggle = 1'b1;
    upd_ir     = '0;
    upd_data   = '0;
    cmd_ready  = 1'b0;
    clr_ovf    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    // Toggle held high through release and priming: no command may appear
    repeat (10) step();
    chk("baseline_level", 64'(fifo_level), 64'd0);
    chk("baseline_valid", 64'(cmd_valid), 64'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].tog, vecs[i].ir, vecs[i].data, vecs[i].ready, vecs[i].clr);
      step();
      chk($sformatf("vec%0d_valid", i), 64'(cmd_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_level", i), 64'(fifo_level), 64'(vecs[i].exp_level));
      chk($sformatf("vec%0d_ta", i), 64'(take_action), 64'(vecs[i].exp_ta));
      chk($sformatf("vec%0d_tna", i), 64'(take_no_action), 64'(vecs[i].exp_tna));
      chk($sformatf("vec%0d_jdo", i), 64'(jdo), 64'(vecs[i].exp_jdo));
      chk($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vecs[i].exp_ovf));
    end
    cmd_ready = 1'b0;

    // Five updates into a four-entry queue with no consumer
    for (int i = 0; i < 5; i++) begin
      da = rand_data();
      da[DATA_W-1] = i[0];
      upd_wait(i[IR_W-1:0], da, 1'b0, 1'b0);
    end
    chk("ovf_level_full", 64'(fifo_level), 64'd4);
    chk("ovf_sticky", 64'(ovf), 64'd1);
    chk("ovf_head_ir", 64'(cmd_ir), 64'd0);

    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 64'(ovf), 64'd0);

    // Write landing on the same edge as a pop while full
    upd_wait(2'd3, rand_data(), 1'b1, 1'b0);
    chk("pushpop_level", 64'(fifo_level), 64'd4);
    chk("pushpop_ovf", 64'(ovf), 64'd0);

    // Overflow set wins over a simultaneous clear
    upd_wait(2'd2, rand_data(), 1'b0, 1'b1);
    chk("set_over_clr", 64'(ovf), 64'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_alone", 64'(ovf), 64'd0);

    cmd_ready = 1'b1;
    repeat (5) step();
    cmd_ready = 1'b0;
    chk("drain_level", 64'(fifo_level), 64'd0);

    // Asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) upd_wait(i[IR_W-1:0], rand_data(), 1'b0, 1'b0);
    chk("pre_reset_level", 64'(fifo_level), 64'd3);
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    upd_toggle = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (S + 4) step();
    chk("post_reset_level", 64'(fifo_level), 64'd0);

    // Randomized traffic with alternating light/heavy consumer phases
    since = S + 2;
    for (int it = 0; it < 600; it++) begin
      phase = it / 100;
      cmd_ready = (phase % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      if (since >= S + 2 && $urandom_range(0, 1) == 1) begin
        drive(~upd_toggle, IR_W'($urandom_range(0, NCH - 1)), rand_data(), cmd_ready, clr_ovf);
        since = 0;
      end
      step();
      since++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
